recall: RTL and testbench

Playback stage downstream of the sequence-storing stage. It reads the words previously written into the sequence memory, from address 0 up to the last written address, and presents each word on `out_data` with a one-cycle `out_valid` strobe. Words are spaced by a programmable step interval. It owns the memory read port and sits between the sequence RAM and the display/output logic.

---
 rtl/sequence_pkg.sv | 23 ++
 rtl/recall_step_timer.sv | 27 ++
 rtl/recall.sv | 127 ++++++++++++
 tb/tb_recall.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sequence_pkg.sv
// Shared definitions for the sequence store, RAM and recall stages.
// Holds default widths, logic-level constants and the recall state encoding.
package sequence_pkg;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  localparam int DEFAULT_WORD_SIZE    = 8;
  localparam int DEFAULT_ADDRESS_SIZE = 4;

  localparam logic [1:0] RECALL_IDLE      = 2'd0;
  localparam logic [1:0] RECALL_REQUEST   = 2'd1;
  localparam logic [1:0] RECALL_WAIT_DATA = 2'd2;
  localparam logic [1:0] RECALL_HOLD      = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = RECALL_IDLE,
    REQUEST   = RECALL_REQUEST,
    WAIT_DATA = RECALL_WAIT_DATA,
    HOLD      = RECALL_HOLD
  } recall_state_t;

endpackage

// File: rtl/recall_step_timer.sv
// Loadable down-counter that paces word presentation; done while the count is 0.
// Counts down on its own after a load and rests at zero.
module step_timer #(
  parameter int WIDTH = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/recall.sv
// Playback stage: reads words 0..end_addr from the sequence RAM and presents
// each on out_data with a one-cycle out_valid strobe, spaced by STEP_CYCLES.
module recall
  import sequence_pkg::*;
#(
  parameter int WORD_SIZE    = DEFAULT_WORD_SIZE,
  parameter int ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE,
  parameter int MEMORY_QTY   = 16,
  parameter int STEP_CYCLES  = 12000000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    play,
  input  logic                    stored,
  input  logic [ADDRESS_SIZE-1:0] last_addr,
  input  logic                    r_ready,
  input  logic                    r_valid,
  input  logic [WORD_SIZE-1:0]    r_data,
  output logic                    r_en,
  output logic [ADDRESS_SIZE-1:0] r_addr,
  output logic [WORD_SIZE-1:0]    out_data,
  output logic                    out_valid,
  output logic                    busy
);

  localparam int TIMER_W = $clog2(STEP_CYCLES);
  localparam logic [TIMER_W-1:0]      STEP_RELOAD = TIMER_W'(STEP_CYCLES - 1);
  localparam logic [ADDRESS_SIZE-1:0] LAST_LOC    = ADDRESS_SIZE'(MEMORY_QTY - 1);

  // Read handshake: r_en is a single-cycle request issued only when r_ready is
  // high in REQUEST; r_valid is honoured only in WAIT_DATA, one read in flight.
  recall_state_t               state, state_nxt;
  logic                        play_d;
  logic                        play_rise;
  logic [ADDRESS_SIZE-1:0]     end_addr, end_addr_nxt;
  logic [ADDRESS_SIZE-1:0]     r_addr_nxt;
  logic [ADDRESS_SIZE-1:0]     start_end;
  logic                        r_en_nxt;
  logic                        out_valid_nxt;
  logic [WORD_SIZE-1:0]        out_data_nxt;
  logic                        timer_load;
  logic                        timer_done;

  assign play_rise = play & ~play_d;
  assign start_end = (last_addr > LAST_LOC) ? LAST_LOC : last_addr;
  assign busy      = (state != IDLE);

  step_timer #(
    .WIDTH(TIMER_W)
  ) u_step_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (STEP_RELOAD),
    .done       (timer_done)
  );

  always_comb begin
    state_nxt     = state;
    r_en_nxt      = OFF;
    out_valid_nxt = OFF;
    out_data_nxt  = out_data;
    r_addr_nxt    = r_addr;
    end_addr_nxt  = end_addr;
    timer_load    = OFF;
    // Dropping play abandons the pass from any active state, even if data lands now.
    if (state != IDLE && !play) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (play_rise && stored) begin
            r_addr_nxt   = '0;
            end_addr_nxt = start_end;
            state_nxt    = REQUEST;
          end
        end
        REQUEST: begin
          if (r_ready) begin
            r_en_nxt  = ON;
            state_nxt = WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (r_valid) begin
            out_data_nxt  = r_data;
            out_valid_nxt = ON;
            timer_load    = ON;
            state_nxt     = HOLD;
          end
        end
        HOLD: begin
          if (timer_done) begin
            if (r_addr == end_addr) begin
              state_nxt = IDLE;
            end else begin
              r_addr_nxt = r_addr + ADDRESS_SIZE'(1);
              state_nxt  = REQUEST;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      play_d    <= OFF;
      r_en      <= OFF;
      r_addr    <= '0;
      end_addr  <= '0;
      out_data  <= '0;
      out_valid <= OFF;
    end else begin
      state     <= state_nxt;
      play_d    <= play;
      r_en      <= r_en_nxt;
      r_addr    <= r_addr_nxt;
      end_addr  <= end_addr_nxt;
      out_data  <= out_data_nxt;
      out_valid <= out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_recall.sv
// Directed bench for recall: RAM model with one-cycle read latency,
// strobe scoreboard and hand-computed timing expectations.
module tb_recall;

  localparam int WS = 8;
  localparam int AS = 4;
  localparam int MQ = 16;
  localparam int SC = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          play;
  logic          stored;
  logic [AS-1:0] last_addr;
  logic          r_ready;
  logic          r_valid;
  logic [WS-1:0] r_data;
  logic          r_en;
  logic [AS-1:0] r_addr;
  logic [WS-1:0] out_data;
  logic          out_valid;
  logic          busy;

  // clock / reset
  always #5 clock = ~clock;

  recall #(
    .WORD_SIZE   (WS),
    .ADDRESS_SIZE(AS),
    .MEMORY_QTY  (MQ),
    .STEP_CYCLES (SC)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .play      (play),
    .stored    (stored),
    .last_addr (last_addr),
    .r_ready   (r_ready),
    .r_valid   (r_valid),
    .r_data    (r_data),
    .r_en      (r_en),
    .r_addr    (r_addr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy)
  );

  // RAM model, read latency 1
  logic [WS-1:0] ram [MQ];
  logic          mem_valid = 1'b0;
  logic          inj_valid;
  int            cyc = 0;

  always @(posedge clock) begin
    mem_valid <= r_en;
    r_data    <= ram[r_addr];
    cyc       <= cyc + 1;
  end
  assign r_valid = mem_valid | inj_valid;

  // scoreboard
  logic [WS-1:0] exp_q[$];
  logic [WS-1:0] got_q[$];
  int            got_cyc_q[$];
  int            ren_cnt, ren_double, busy_cnt;
  logic          prev_ren;
  int            n_checks = 0;
  int            n_pass = 0;
  int            c_n, t_idle, c_r;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(negedge clock);
    if (out_valid) begin
      got_q.push_back(out_data);
      got_cyc_q.push_back(cyc);
    end
    if (r_en) ren_cnt++;
    if (r_en && prev_ren) ren_double++;
    prev_ren = r_en;
    if (busy) busy_cnt++;
  endtask

  task automatic clear_obs();
    got_q.delete();
    got_cyc_q.delete();
    exp_q.delete();
    ren_cnt = 0;
    ren_double = 0;
    busy_cnt = 0;
  endtask

  task automatic wait_idle(input string tag, input int max, output int c);
    int i;
    i = 0;
    while (busy && i < max) begin
      tick();
      i++;
    end
    c = cyc;
    check(tag, busy, 0);
  endtask

  task automatic wait_strobes(input string tag, input int n, input int max);
    for (int i = 0; i < max && got_q.size() < n; i++) tick();
    check(tag, got_q.size(), n);
  endtask

  task automatic score(input string tag);
    logic [WS-1:0] e, g;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      check({tag, "_data"}, g, e);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_r_en"}, r_en, 0);
    check({tag, "_r_addr"}, r_addr, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < MQ; i++) ram[i] = WS'(8'h11 * (i + 1));
    reset = 1'b1; play = 1'b0; stored = 1'b0; last_addr = '0;
    r_ready = 1'b1; inj_valid = 1'b0; prev_ren = 1'b0;
    clear_obs();
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (2) tick();

    // full pass: 11,22,33,44 spaced 7 cycles
    stored = 1'b1; last_addr = 4'd3; clear_obs();
    play = 1'b1;
    tick();
    c_n = cyc;
    check("t1_busy_start", busy, 1);
    wait_idle("t1_idle", 100, t_idle);
    repeat (10) tick();
    check("t1_first_latency", got_cyc_q.size() > 0 ? got_cyc_q[0] - c_n : -1, 3);
    for (int i = 1; i < got_cyc_q.size(); i++)
      check("t1_spacing", got_cyc_q[i] - got_cyc_q[i-1], 7);
    check("t1_busy_drop", t_idle - c_n, 28);
    check("t1_ren_count", ren_cnt, 4);
    check("t1_ren_double", ren_double, 0);
    check("t1_no_restart", busy, 0);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    score("t1");
    play = 1'b0;
    tick();

    // empty memory
    stored = 1'b0; clear_obs();
    play = 1'b1;
    repeat (10) tick();
    check("t2_busy_cnt", busy_cnt, 0);
    check("t2_ren_cnt", ren_cnt, 0);
    play = 1'b0; stored = 1'b1;
    tick();

    // backpressure
    last_addr = 4'd0; r_ready = 1'b0; clear_obs();
    play = 1'b1;
    repeat (5) tick();
    check("t3_ren_held", ren_cnt, 0);
    check("t3_busy", busy, 1);
    r_ready = 1'b1;
    c_r = cyc;
    tick();
    check("t3_ren_rise", r_en, 1);
    check("t3_ren_delay", cyc - c_r, 1);
    check("t3_addr", r_addr, 0);
    wait_idle("t3_idle", 50, t_idle);
    exp_q.push_back(8'h11);
    score("t3");
    play = 1'b0;
    tick();

    // abort during HOLD of word 1
    last_addr = 4'd3; clear_obs();
    play = 1'b1;
    wait_strobes("t4_two_words", 2, 60);
    check("t4_addr_before", r_addr, 1);
    play = 1'b0;
    tick();
    check("t4_busy", busy, 0);
    check("t4_out_data", out_data, 8'h22);
    check("t4_r_addr", r_addr, 1);
    check("t4_out_valid", out_valid, 0);
    tick();
    clear_obs();
    play = 1'b1;
    for (int i = 0; i < 20 && ren_cnt == 0; i++) tick();
    check("t4_restart_ren", ren_cnt, 1);
    check("t4_restart_addr", r_addr, 0);
    wait_strobes("t4_restart_word", 1, 20);
    exp_q.push_back(8'h11);
    score("t4");
    play = 1'b0;
    tick();

    // length latched at start
    last_addr = 4'd1; clear_obs();
    play = 1'b1;
    wait_strobes("t5_first", 1, 40);
    last_addr = 4'd5;
    wait_idle("t5_idle", 80, t_idle);
    repeat (5) tick();
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    score("t5");
    play = 1'b0;
    tick();

    // async reset in WAIT_DATA
    last_addr = 4'd3; clear_obs();
    play = 1'b1;
    for (int i = 0; i < 20 && !r_en; i++) tick();
    check("t6_ren_seen", r_en, 1);
    tick();
    #1;
    reset = 1'b1; play = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    repeat (2) tick();
    reset = 1'b0;
    clear_obs();
    inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    repeat (5) tick();
    check("t6_no_strobe", got_q.size(), 0);
    check("t6_idle", busy_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
